// File: rtl/fpu_byte_sequencer_if.sv
// ---------------------------------------------------------------------------
// fpu_byte_sequencer_if
// Groups every non-clock signal of the byte sequencer. The byte stream runs
// between the chip pins and the sequencer, and the operand/result buses run
// between the sequencer and the FPU.
//
// Signals
//   in_data   [7:0]  input byte              in_valid / in_ready   input handshake
//   out_data  [7:0]  result byte             out_valid / out_ready output handshake
//   fpu_add, fpu_sub one-cycle operation strobes to the FPU
//   fpu_reg1_s/e/m   operand A (1/7/15 bits)   fpu_reg2_s/e/m operand B
//   fpu_res_s/e/m    FPU result (1/7/15 bits)  fpu_idle       FPU idle flag
//   busy             operation in progress     err            sticky error flag
//
// Modports
//   master : the sequencer itself
//   slave  : its surroundings (byte source/sink and the FPU)
// ---------------------------------------------------------------------------
interface fpu_byte_sequencer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        fpu_add;
  logic        fpu_sub;
  logic        fpu_reg1_s;
  logic [6:0]  fpu_reg1_e;
  logic [14:0] fpu_reg1_m;
  logic        fpu_reg2_s;
  logic [6:0]  fpu_reg2_e;
  logic [14:0] fpu_reg2_m;
  logic        fpu_res_s;
  logic [6:0]  fpu_res_e;
  logic [14:0] fpu_res_m;
  logic        fpu_idle;
  logic        busy;
  logic        err;

  modport master (
    input  in_data, in_valid, out_ready,
    input  fpu_res_s, fpu_res_e, fpu_res_m, fpu_idle,
    output in_ready, out_data, out_valid,
    output fpu_add, fpu_sub,
    output fpu_reg1_s, fpu_reg1_e, fpu_reg1_m,
    output fpu_reg2_s, fpu_reg2_e, fpu_reg2_m,
    output busy, err
  );

  modport slave (
    output in_data, in_valid, out_ready,
    output fpu_res_s, fpu_res_e, fpu_res_m, fpu_idle,
    input  in_ready, out_data, out_valid,
    input  fpu_add, fpu_sub,
    input  fpu_reg1_s, fpu_reg1_e, fpu_reg1_m,
    input  fpu_reg2_s, fpu_reg2_e, fpu_reg2_m,
    input  busy, err
  );
endinterface

// File: rtl/fpu_byte_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_byte_sequencer
// Byte-stream front end for the FPU. It collects a command byte (01 = add,
// 02 = sub) followed by two 3-byte float operands, drives them onto the FPU
// operand buses, issues one add/sub strobe, waits for the FPU to go busy and
// then idle again, captures the result, and streams the 3 result bytes out.
//
// Float format: 1b sign, 7b two's-complement exponent, 15b mantissa.
// Byte packing: b0 = {s, e[6:0]}, b1 = m[14:7], b2 = {m[6:0], 1'b0}.
//
// Ports
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : fpu_byte_sequencer_if.master (byte stream, FPU buses, busy, err)
//
// Parameters
//   TIMEOUT : cycles allowed in each FPU wait state before aborting with err
// ---------------------------------------------------------------------------
module fpu_byte_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  fpu_byte_sequencer_if.master       bus
);

  localparam logic [2:0] S_CMD       = 3'd0;
  localparam logic [2:0] S_LOADA     = 3'd1;
  localparam logic [2:0] S_LOADB     = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_WAIT_BUSY = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_SEND      = 3'd6;

  localparam logic [7:0] CMD_ADD = 8'h01;
  localparam logic [7:0] CMD_SUB = 8'h02;

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    state;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] tcnt;
  logic          op_sub;
  logic [22:0]   result;     // {s, e[6:0], m[14:0]}
  logic          busy_q;
  logic          err_q;

  logic          reg1_s;
  logic [6:0]    reg1_e;
  logic [14:0]   reg1_m;
  logic          reg2_s;
  logic [6:0]    reg2_e;
  logic [14:0]   reg2_m;

  logic          in_fire;
  logic          out_fire;
  logic          cmd_ok;
  logic          timeout_hit;
  logic [7:0]    send_byte;

  // ---------------------------------------------------------------------------
  // Handshake and strobe decode
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = (state == S_CMD) || (state == S_LOADA) || (state == S_LOADB);
  assign bus.out_valid = (state == S_SEND);

  assign in_fire  = bus.in_valid  & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  assign cmd_ok = (bus.in_data == CMD_ADD) || (bus.in_data == CMD_SUB);

  // The wait-state counter starts at 0 on the first cycle in the state, so the
  // compare against TIMEOUT-1 fires on the TIMEOUT-th cycle spent waiting.
  assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));

  // ISSUE holds until the FPU is idle and leaves on the same edge the strobe
  // is seen, so each strobe is exactly one cycle wide and never both at once.
  assign bus.fpu_add = (state == S_ISSUE) & bus.fpu_idle & ~op_sub;
  assign bus.fpu_sub = (state == S_ISSUE) & bus.fpu_idle &  op_sub;

  // Current output byte. Depends only on registered state, so it stays put
  // while the consumer stalls.
  always_comb begin
    // NOTE: default assignment first keeps this always_comb free of latches.
    send_byte = 8'h00;
    if (state == S_SEND) begin
      unique case (byte_cnt)
        2'd0:    send_byte = result[22:15];
        2'd1:    send_byte = result[14:7];
        default: send_byte = {result[6:0], 1'b0};
      endcase
    end
  end

  assign bus.out_data   = send_byte;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.fpu_reg1_s = reg1_s;
  assign bus.fpu_reg1_e = reg1_e;
  assign bus.fpu_reg1_m = reg1_m;
  assign bus.fpu_reg2_s = reg2_s;
  assign bus.fpu_reg2_e = reg2_e;
  assign bus.fpu_reg2_m = reg2_m;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_CMD;
      byte_cnt <= '0;
      tcnt     <= '0;
      op_sub   <= 1'b0;
      // NOTE: the result and operand registers are reset as well, so the
      // operand buses and out_data read 0 after reset rather than stale data.
      result   <= '0;
      reg1_s   <= 1'b0;
      reg1_e   <= '0;
      reg1_m   <= '0;
      reg2_s   <= 1'b0;
      reg2_e   <= '0;
      reg2_m   <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        S_CMD: begin
          if (in_fire) begin
            if (cmd_ok) begin
              op_sub   <= (bus.in_data == CMD_SUB);
              err_q    <= 1'b0;
              busy_q   <= 1'b1;
              byte_cnt <= '0;
              state    <= S_LOADA;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        // Operand bytes go straight into the FPU operand registers; the buses
        // are not touched again until the next command, which keeps them
        // stable for the whole FPU operation.
        S_LOADA: begin
          if (in_fire) begin
            unique case (byte_cnt)
              2'd0: begin
                reg1_s <= bus.in_data[7];
                reg1_e <= bus.in_data[6:0];
              end
              2'd1:    reg1_m[14:7] <= bus.in_data;
              default: reg1_m[6:0]  <= bus.in_data[7:1];
            endcase
            if (byte_cnt == 2'd2) begin
              byte_cnt <= '0;
              state    <= S_LOADB;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end

        S_LOADB: begin
          if (in_fire) begin
            unique case (byte_cnt)
              2'd0: begin
                reg2_s <= bus.in_data[7];
                reg2_e <= bus.in_data[6:0];
              end
              2'd1:    reg2_m[14:7] <= bus.in_data;
              default: reg2_m[6:0]  <= bus.in_data[7:1];
            endcase
            if (byte_cnt == 2'd2) begin
              byte_cnt <= '0;
              state    <= S_ISSUE;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end

        S_ISSUE: begin
          if (bus.fpu_idle) begin
            tcnt  <= '0;
            state <= S_WAIT_BUSY;
          end
        end

        S_WAIT_BUSY: begin
          if (!bus.fpu_idle) begin
            tcnt  <= '0;
            state <= S_WAIT_DONE;
          end else if (timeout_hit) begin
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_CMD;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_WAIT_DONE: begin
          if (bus.fpu_idle) begin
            result   <= {bus.fpu_res_s, bus.fpu_res_e, bus.fpu_res_m};
            byte_cnt <= '0;
            state    <= S_SEND;
          end else if (timeout_hit) begin
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_CMD;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_SEND: begin
          if (out_fire) begin
            if (byte_cnt == 2'd2) begin
              byte_cnt <= '0;
              busy_q   <= 1'b0;
              state    <= S_CMD;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end

        default: state <= S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_byte_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fpu_byte_sequencer
// Drives byte commands into fpu_byte_sequencer and plays the FPU with a small
// stub that captures the operands on each strobe, goes busy for a chosen
// number of cycles and then presents a chosen result. Expected operand values
// and result bytes come from the float packing rules written as arithmetic.
// ---------------------------------------------------------------------------
module tb_fpu_byte_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fpu_byte_sequencer_if bus ();

  fpu_byte_sequencer #(.TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // ---------------------------------------------------------------------------
  // FPU stub
  // ---------------------------------------------------------------------------
  logic        stuck_idle = 1'b0;
  logic [22:0] stub_res   = '0;
  int          stub_lat   = 3;

  logic        stub_idle  = 1'b1;
  logic [22:0] stub_out   = '0;
  int          rem        = 0;
  int          add_cnt    = 0;
  int          sub_cnt    = 0;
  int          unstable_cnt = 0;
  logic [22:0] cap_a      = '0;
  logic [22:0] cap_b      = '0;

  assign bus.fpu_idle = stub_idle;
  assign {bus.fpu_res_s, bus.fpu_res_e, bus.fpu_res_m} = stub_out;

  always @(posedge clk) begin
    if (bus.fpu_add === 1'b1) add_cnt <= add_cnt + 1;
    if (bus.fpu_sub === 1'b1) sub_cnt <= sub_cnt + 1;
    if ((bus.fpu_add | bus.fpu_sub) === 1'b1) begin
      cap_a <= {bus.fpu_reg1_s, bus.fpu_reg1_e, bus.fpu_reg1_m};
      cap_b <= {bus.fpu_reg2_s, bus.fpu_reg2_e, bus.fpu_reg2_m};
      if (!stuck_idle) begin
        stub_idle <= 1'b0;
        rem       <= stub_lat;
      end
    end else if (!stub_idle) begin
      if ({bus.fpu_reg1_s, bus.fpu_reg1_e, bus.fpu_reg1_m} !== cap_a ||
          {bus.fpu_reg2_s, bus.fpu_reg2_e, bus.fpu_reg2_m} !== cap_b)
        unstable_cnt <= unstable_cnt + 1;
      if (rem <= 1) begin
        stub_idle <= 1'b1;
        stub_out  <= stub_res;
      end else begin
        rem <= rem - 1;
      end
    end
  end

  // Whenever a strobe is up, the other one must be down.
  always @(negedge clk) begin
    if ((bus.fpu_add | bus.fpu_sub) === 1'b1)
      check("strobe_exclusive", 32'(bus.fpu_add & bus.fpu_sub), 32'd0);
  end

  // ---------------------------------------------------------------------------
  // Reference packing rules
  // ---------------------------------------------------------------------------
  function automatic logic [22:0] unpack(input logic [23:0] bytes);
    int b0, b1, b2, s, e, m;
    b0 = int'(bytes[23:16]);
    b1 = int'(bytes[15:8]);
    b2 = int'(bytes[7:0]);
    s  = b0 / 128;
    e  = b0 % 128;
    m  = b1 * 128 + b2 / 2;
    return 23'(s * 4194304 + e * 32768 + m);
  endfunction

  function automatic logic [7:0] pack_byte(input logic [22:0] r, input int idx);
    int v, s, e, m;
    v = int'(r);
    s = v / 4194304;
    e = (v / 32768) % 128;
    m = v % 32768;
    if (idx == 0) return 8'(s * 128 + e);
    if (idx == 1) return 8'(m / 128);
    return 8'((m % 128) * 2);
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    else tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] expected);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (bus.out_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check(tag, 32'(bus.out_data), 32'(expected));
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic load_operands(input logic [23:0] a, input logic [23:0] b, input int gap);
    for (int i = 0; i < 3; i++) begin
      repeat (gap) tick();
      send_byte(a[23 - 8*i -: 8]);
    end
    for (int i = 0; i < 3; i++) begin
      repeat (gap) tick();
      send_byte(b[23 - 8*i -: 8]);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] cmd, input logic [23:0] a,
                        input logic [23:0] b, input logic [22:0] res, input int lat,
                        input int gap);
    int a0, s0, u0;
    a0 = add_cnt;
    s0 = sub_cnt;
    u0 = unstable_cnt;
    stub_res = res;
    stub_lat = lat;
    send_byte(cmd);
    check({tag, "_busy_set"}, 32'(bus.busy), 32'd1);
    check({tag, "_err_clear"}, 32'(bus.err), 32'd0);
    load_operands(a, b, gap);
    for (int i = 0; i < 3; i++)
      recv_byte($sformatf("%s_out%0d", tag, i), pack_byte(res, i));
    check({tag, "_opA"}, 32'(cap_a), 32'(unpack(a)));
    check({tag, "_opB"}, 32'(cap_b), 32'(unpack(b)));
    check({tag, "_add_pulses"}, 32'(add_cnt - a0), (cmd == 8'h01) ? 32'd1 : 32'd0);
    check({tag, "_sub_pulses"}, 32'(sub_cnt - s0), (cmd == 8'h02) ? 32'd1 : 32'd0);
    check({tag, "_operands_stable"}, 32'(unstable_cnt - u0), 32'd0);
    check({tag, "_busy_clear"}, 32'(bus.busy), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
    check({tag, "_strobes"},   32'({bus.fpu_add, bus.fpu_sub}), 32'd0);
    check({tag, "_reg1"}, 32'({bus.fpu_reg1_s, bus.fpu_reg1_e, bus.fpu_reg1_m}), 32'd0);
    check({tag, "_reg2"}, 32'({bus.fpu_reg2_s, bus.fpu_reg2_e, bus.fpu_reg2_m}), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_err"},  32'(bus.err),  32'd0);
  endtask

  localparam logic [23:0] ONE     = 24'h008000;
  localparam logic [22:0] TWO_RES = {1'b0, 7'd1, 15'h4000};
  localparam logic [22:0] ZERO_RES = {1'b0, 7'h40, 15'h4000};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed and randomized sequence
  // ---------------------------------------------------------------------------
  initial begin
    int a0, n;
    logic seen_valid;

    reset         = 1'b1;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    reset = 1'b0;
    tick();

    // 1.0 + 1.0 and 1.0 - 1.0
    run_op("add_1p1", 8'h01, ONE, ONE, TWO_RES, 3, 0);
    run_op("sub_1m1", 8'h02, ONE, ONE, ZERO_RES, 5, 1);

    // Bad commands set err without starting an op; a good one clears it.
    send_byte(8'h07);
    check("badcmd_err", 32'(bus.err), 32'd1);
    check("badcmd_busy", 32'(bus.busy), 32'd0);
    check("badcmd_in_ready", 32'(bus.in_ready), 32'd1);
    send_byte(8'hFF);
    check("badcmd2_err", 32'(bus.err), 32'd1);
    run_op("after_bad", 8'h01, ONE, ONE, TWO_RES, 2, 0);

    // FPU never leaves idle: abort after 64 cycles in WAIT_BUSY, no output.
    stuck_idle = 1'b1;
    a0 = add_cnt;
    send_byte(8'h01);
    load_operands(ONE, ONE, 0);
    n = 0;
    seen_valid = 1'b0;
    bus.out_ready = 1'b1;
    while (bus.err !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (bus.out_valid === 1'b1) seen_valid = 1'b1;
    end
    bus.out_ready = 1'b0;
    check("timeout_cycles", 32'(n), 32'd65);
    check("timeout_err", 32'(bus.err), 32'd1);
    check("timeout_no_output", 32'(seen_valid), 32'd0);
    check("timeout_busy", 32'(bus.busy), 32'd0);
    check("timeout_in_ready", 32'(bus.in_ready), 32'd1);
    check("timeout_add_pulses", 32'(add_cnt - a0), 32'd1);
    stuck_idle = 1'b0;

    // Consumer stalls for 10 cycles on result byte 1.
    stub_res = TWO_RES;
    stub_lat = 4;
    send_byte(8'h01);
    check("bp_err_clear", 32'(bus.err), 32'd0);
    load_operands(ONE, ONE, 0);
    recv_byte("bp_out0", 8'h01);
    repeat (10) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h80) seen_valid = 1'b0;
    end
    check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    check("bp_hold_data", 32'(bus.out_data), 32'h80);
    recv_byte("bp_out1", 8'h80);
    recv_byte("bp_out2", 8'h00);
    check("bp_busy_clear", 32'(bus.busy), 32'd0);

    // Reset while the sequencer waits for the FPU to finish.
    stub_lat = 40;
    send_byte(8'h01);
    load_operands(ONE, ONE, 0);
    n = 0;
    while (bus.fpu_idle !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    check("midop_fpu_busy", 32'(bus.fpu_idle), 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_reset_state("midop_reset");
    reset = 1'b0;
    n = 0;
    while (bus.fpu_idle !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("midop_fpu_done", 32'(bus.fpu_idle), 32'd1);
    check("midop_no_output", 32'(bus.out_valid), 32'd0);
    run_op("after_reset", 8'h01, ONE, ONE, TWO_RES, 3, 0);

    // Randomized operations.
    for (int i = 0; i < 8; i++) begin
      logic [7:0]  cmd;
      logic [23:0] a, b;
      logic [22:0] r;
      cmd = 8'($urandom_range(1, 2));
      a   = 24'($urandom);
      b   = 24'($urandom);
      r   = 23'($urandom);
      run_op($sformatf("rand%0d", i), cmd, a, b, r,
             int'($urandom_range(1, 8)), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
